// File: rtl/sha256_msg_sched_pkg.sv
// Shared SHA-256 definitions: FSM state encoding, schedule constants, sigma/choice/majority functions.
// Latency: n/a (package only).
// Backpressure: n/a.
package sha256_msg_sched_pkg;

  localparam int SCHED_ADDR_W  = 15;
  localparam int SCHED_ROUNDS  = 64;
  localparam int SCHED_BLK_WDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXPAND = 2'd2
  } state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message schedule small sigmas
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Compression round big sigmas and bitwise selectors
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_sched_sigma.sv
// Combinational s0/s1 pair feeding the schedule adder tree.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
module sha256_msg_sched_sigma
  import sha256_msg_sched_pkg::*;
(
  input  logic [31:0] s0_x_i,
  input  logic [31:0] s1_x_i,
  output logic [31:0] s0_o,
  output logic [31:0] s1_o
);

  // Evaluate both small sigmas on their window taps
  always_comb begin
    s0_o = sig0(s0_x_i);
    s1_o = sig1(s1_x_i);
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// Fetches a 16-word block from RAM and streams the 64-word SHA-256 schedule W[0..63].
// Latency: first word valid 1 cycle after START accepted; 1 word/cycle with W_READY high.
// Backpressure: W_READY low freezes all outputs and the RAM address until the word is taken.
module sha256_msg_sched
  import sha256_msg_sched_pkg::*;
#(
  parameter int ADDR_W  = SCHED_ADDR_W,
  parameter int ROUNDS  = SCHED_ROUNDS,
  parameter int BLK_WDS = SCHED_BLK_WDS
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BLOCK_BASE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_EN_N,
  input  logic [31:0]       RAM_DATA,
  output logic [31:0]       W_OUT,
  output logic [5:0]        W_INDEX,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              BUSY,
  output logic              DONE
);

  state_e            state_q, state_d;
  logic [5:0]        t_q, t_d;
  logic [ADDR_W-1:0] base_q, base_d;
  // win_q[0] is the most recent word W[t-1], win_q[15] is W[t-16]
  logic [31:0]       win_q [16];
  logic [31:0]       win_d [16];
  logic [31:0]       w_out_q, w_out_d;
  logic [5:0]        w_idx_q, w_idx_d;
  logic              w_vld_q, w_vld_d;
  logic              done_q, done_d;

  logic              adv;
  logic              last_held;
  logic              load;
  logic [31:0]       new_word;
  logic [31:0]       expand_word;
  logic [31:0]       sig0_w, sig1_w;

  sha256_msg_sched_sigma u_sigma (
    .s0_x_i (win_q[14]),
    .s1_x_i (win_q[1]),
    .s0_o   (sig0_w),
    .s1_o   (sig1_w)
  );

  // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], carries discarded
  assign expand_word = sig1_w + win_q[6] + sig0_w + win_q[15];

  // Next-state, window shift and output register update
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    base_d   = base_q;
    win_d    = win_q;
    w_out_d  = w_out_q;
    w_idx_d  = w_idx_q;
    w_vld_d  = w_vld_q;
    done_d   = 1'b0;
    load     = 1'b0;
    adv      = ~w_vld_q | W_READY;
    // Final word is sitting in the output register waiting to be taken
    last_held = w_vld_q & (w_idx_q == 6'(ROUNDS - 1));
    new_word  = (state_q == ST_FETCH) ? RAM_DATA : expand_word;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          base_d  = BLOCK_BASE;
          t_d     = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (adv) begin
          load = 1'b1;
          if (t_q == 6'(BLK_WDS - 1)) begin
            state_d = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        if (last_held) begin
          if (W_READY) begin
            w_vld_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (adv) begin
          load = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      w_out_d  = new_word;
      w_idx_d  = t_q;
      w_vld_d  = 1'b1;
      t_d      = t_q + 6'd1;
      win_d[0] = new_word;
      for (int i = 1; i < 16; i++) begin
        win_d[i] = win_q[i-1];
      end
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      base_q  <= '0;
      w_out_q <= '0;
      w_idx_q <= '0;
      w_vld_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      base_q  <= base_d;
      w_out_q <= w_out_d;
      w_idx_q <= w_idx_d;
      w_vld_q <= w_vld_d;
      done_q  <= done_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign RAM_ADDR = base_q + ADDR_W'(t_q);
  assign RAM_EN_N = (state_q != ST_FETCH);
  assign BUSY     = (state_q != ST_IDLE);
  assign W_OUT    = w_out_q;
  assign W_INDEX  = w_idx_q;
  assign W_VALID  = w_vld_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [14:0] BLOCK_BASE;
  logic [14:0] RAM_ADDR;
  logic        RAM_EN_N;
  logic [31:0] RAM_DATA;
  logic [31:0] W_OUT;
  logic [5:0]  W_INDEX;
  logic        W_VALID;
  logic        W_READY;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem   [0:32767];
  logic [31:0] exp_w [64];
  logic [31:0] got   [64];

  sha256_msg_sched dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .BLOCK_BASE (BLOCK_BASE),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_EN_N   (RAM_EN_N),
    .RAM_DATA   (RAM_DATA),
    .W_OUT      (W_OUT),
    .W_INDEX    (W_INDEX),
    .W_VALID    (W_VALID),
    .W_READY    (W_READY),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  // Asynchronous read-only RAM
  assign RAM_DATA = mem[RAM_ADDR];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [14:0] base;
    int          fill;     // 0 "abc", 1 all ones, 2 random
    int          mode;     // 0 ready=1, 1 toggle, 2 random
    logic        chk_lo;   // compare W16/W17 with constants
    logic        chk_63;   // compare W63 with constant
    logic [31:0] e16;
    logic [31:0] e17;
    logic [31:0] e63;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Textbook schedule recurrence over the whole block held in memory
  task automatic build_ref(input logic [14:0] base);
    for (int i = 0; i < 16; i++) exp_w[i] = mem[15'(base + i)];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic fill(input logic [14:0] base, input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       mem[15'(base + i)] = (i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0;
        1:       mem[15'(base + i)] = 32'hFFFFFFFF;
        default: mem[15'(base + i)] = $urandom;
      endcase
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_w_out"},    W_OUT,    32'h0);
    chk({tag, "_w_index"},  W_INDEX,  32'h0);
    chk({tag, "_w_valid"},  W_VALID,  32'h0);
    chk({tag, "_busy"},     BUSY,     32'h0);
    chk({tag, "_done"},     DONE,     32'h0);
    chk({tag, "_ram_en_n"}, RAM_EN_N, 32'h1);
    chk({tag, "_ram_addr"}, RAM_ADDR, 32'h0);
  endtask

  // Run one block from IDLE; returns cycles from the START-accepting edge to DONE
  task automatic run_block(input logic [14:0] base, input int mode, input logic hold_start,
                           output int cycles);
    int          n;
    int          loaded;
    logic        fin;
    logic        stall_prev;
    logic [31:0] prev_out;
    logic [5:0]  prev_idx;
    build_ref(base);
    n = 0; fin = 1'b0; stall_prev = 1'b0; prev_out = '0; prev_idx = '0; cycles = -1;
    BLOCK_BASE = base;
    START      = 1'b1;
    step();
    START      = hold_start;
    BLOCK_BASE = 15'($urandom);
    chk("accept_busy",     BUSY,     32'h1);
    chk("accept_ram_en_n", RAM_EN_N, 32'h0);
    chk("accept_w_valid",  W_VALID,  32'h0);
    chk("accept_done_low", DONE,     32'h0);
    for (int k = 1; k <= 2000 && !fin; k++) begin
      case (mode)
        0:       W_READY = 1'b1;
        1:       W_READY = k[0];
        default: W_READY = 1'($urandom_range(0, 1));
      endcase
      if (stall_prev) begin
        chk("stall_w_out",   W_OUT,   prev_out);
        chk("stall_w_index", W_INDEX, prev_idx);
        chk("stall_w_valid", W_VALID, 32'h1);
      end
      loaded = n + int'(W_VALID);
      chk("ram_en_n", RAM_EN_N, (loaded < 16) ? 32'h0 : 32'h1);
      if (loaded < 16) chk("ram_addr", RAM_ADDR, 32'(15'(base + loaded)));
      if (W_VALID && W_READY) begin
        if (n < 64) begin
          got[n] = W_OUT;
          chk("w_index", W_INDEX, n);
          chk("w_out",   W_OUT,   exp_w[n]);
        end
        n++;
      end
      stall_prev = W_VALID & ~W_READY;
      prev_out   = W_OUT;
      prev_idx   = W_INDEX;
      step();
      if (DONE) begin
        fin    = 1'b1;
        cycles = k;
        chk("done_after_w63", n,       64);
        chk("done_busy",      BUSY,    32'h0);
        chk("done_w_valid",   W_VALID, 32'h0);
      end
    end
    if (!fin) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got no DONE after 2000 cycles, required DONE after 64 transfers (%0d seen)", n);
    end
    W_READY = 1'b0;
  endtask

  vec_t tbl [6];
  int   cyc, cyc2;

  initial begin
    // s1(FFFFFFFF)=003FFFFF, s0(FFFFFFFF)=1FFFFFFF; 003FFFFF+FFFFFFFF+1FFFFFFF+FFFFFFFF = 203FFFFC
    tbl[0] = '{15'h0000, 0, 0, 1'b1, 1'b1, 32'h61626380, 32'h000F0000, 32'h12B1EDEB};
    tbl[1] = '{15'h0000, 0, 1, 1'b1, 1'b1, 32'h61626380, 32'h000F0000, 32'h12B1EDEB};
    tbl[2] = '{15'h7FF8, 1, 0, 1'b1, 1'b0, 32'h203FFFFC, 32'h203FFFFC, 32'h0};
    tbl[3] = '{15'h7FF8, 2, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{15'h1234, 2, 2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[5] = '{15'h4000, 0, 2, 1'b1, 1'b1, 32'h61626380, 32'h000F0000, 32'h12B1EDEB};

    RST_N = 1'b0; START = 1'b0; BLOCK_BASE = '0; W_READY = 1'b0;
    repeat (3) step();
    check_reset_vals("reset");
    RST_N = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      fill(tbl[v].base, tbl[v].fill);
      run_block(tbl[v].base, tbl[v].mode, 1'b0, cyc);
      if (tbl[v].chk_lo) begin
        chk($sformatf("vec%0d_w16", v), got[16], tbl[v].e16);
        chk($sformatf("vec%0d_w17", v), got[17], tbl[v].e17);
      end
      if (tbl[v].chk_63) chk($sformatf("vec%0d_w63", v), got[63], tbl[v].e63);
      if (tbl[v].mode == 0) chk($sformatf("vec%0d_start_to_done", v), cyc, 65);
      step();
    end

    // Reset in the middle of EXPAND: partial block dropped, no DONE
    fill(15'h0100, 2);
    BLOCK_BASE = 15'h0100; START = 1'b1;
    step();
    START = 1'b0; W_READY = 1'b1;
    repeat (20) step();
    RST_N = 1'b0;
    step();
    check_reset_vals("midrst");
    RST_N = 1'b1; W_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_done", DONE, 32'h0);
      chk("midrst_idle",    BUSY, 32'h0);
    end
    W_READY = 1'b0;
    run_block(15'h0100, 0, 1'b0, cyc);
    chk("midrst_restart_cycles", cyc, 65);

    // START held through the block, then back-to-back block from the DONE cycle
    fill(15'h0200, 2);
    fill(15'h0300, 0);
    run_block(15'h0200, 0, 1'b1, cyc);
    chk("hold_start_cycles", cyc, 65);
    run_block(15'h0300, 0, 1'b0, cyc2);
    chk("b2b_w63", got[63], 32'h12B1EDEB);
    chk("b2b_cycles", cyc2, 65);
    step();

    // Randomized blocks against the reference recurrence
    for (int r = 0; r < 5; r++) begin
      logic [14:0] b;
      b = 15'($urandom);
      fill(b, 2);
      run_block(b, int'($urandom_range(0, 2)), 1'b0, cyc);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
